spi_txn_sequencer: RTL and testbench

Transaction front-end that sits directly upstream of the three-slave SPI top level. It buffers host write/read requests in a small FIFO and selects one slave per request. It then drives the chip-select lines and `master_data` for a fixed transfer window, captures the word returned on `master_r`, and presents it on a valid/ready response port. It serializes all traffic so that at most one chip select is active at any time.

---
 rtl/spi_txn_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_spi_txn_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_sequencer.sv
// rtl/spi_txn_sequencer.sv - request FIFO and chip-select sequencer in front of the three-slave SPI top
//
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   req_valid/req_ready            request handshake; req_slave (1..3, 0 illegal), req_data
//   rsp_valid/rsp_ready            response handshake; rsp_slave, rsp_data, rsp_err
//   cs1, cs2, cs3                  active-low chip selects, at most one low at a time
//   master_data, master_r          word sent to / received from the SPI master
//   busy                           FSM not idle or requests still queued
module spi_txn_sequencer #(
  parameter int XFER_CYCLES = 17,
  parameter int GAP_CYCLES  = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_slave,
  input  logic [15:0] req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_slave,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        cs1,
  output logic        cs2,
  output logic        cs3,
  output logic [15:0] master_data,
  input  logic [15:0] master_r,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0]    XFER_LOAD  = 8'(XFER_CYCLES - 1);
  localparam logic [3:0]    GAP_LOAD   = 4'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_XFER    = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4,
    S_GAP     = 3'd5
  } state_e;

  state_e state_q, state_d;

  // request FIFO
  logic [1:0]    fifo_slave_q [FIFO_DEPTH];
  logic [15:0]   fifo_data_q  [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push, pop, empty, full;
  logic [1:0]    head_slave;
  logic [15:0]   head_data;

  // transfer bookkeeping
  logic [7:0]  xfer_cnt_q, xfer_cnt_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic [1:0]  slave_q, slave_d;
  logic        err_q, err_d;

  // registered outputs
  logic        cs1_q, cs1_d, cs2_q, cs2_d, cs3_q, cs3_d;
  logic [15:0] master_data_q, master_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_slave_q, rsp_slave_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  assign empty      = (count_q == '0);
  assign full       = (count_q == FULL_COUNT);
  assign req_ready  = !full;
  assign push       = req_valid && !full;
  assign pop        = (state_q == S_IDLE) && !empty;
  assign head_slave = fifo_slave_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];
  assign busy       = (state_q != S_IDLE) || !empty;

  // FIFO storage needs no reset: count_q alone decides what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_slave_q[wr_ptr_q] <= req_slave;
      fifo_data_q[wr_ptr_q]  <= req_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      xfer_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      slave_q       <= '0;
      err_q         <= 1'b0;
      cs1_q         <= 1'b1;
      cs2_q         <= 1'b1;
      cs3_q         <= 1'b1;
      master_data_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_slave_q   <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      xfer_cnt_q    <= xfer_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      slave_q       <= slave_d;
      err_q         <= err_d;
      cs1_q         <= cs1_d;
      cs2_q         <= cs2_d;
      cs3_q         <= cs3_d;
      master_data_q <= master_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_slave_q   <= rsp_slave_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d    = state_q;
    xfer_cnt_d = xfer_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        // slave 0 skips the bus entirely and only produces an error response
        if (pop) state_d = (head_slave == 2'd0) ? S_RESP : S_SETUP;
      end
      S_SETUP: begin
        state_d    = S_XFER;
        xfer_cnt_d = XFER_LOAD;
      end
      S_XFER: begin
        if (xfer_cnt_q == 8'd0) state_d = S_CAPTURE;
        else                    xfer_cnt_d = xfer_cnt_q - 8'd1;
      end
      S_CAPTURE: state_d = S_RESP;
      S_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d   = S_GAP;
          gap_cnt_d = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == 4'd0) state_d = S_IDLE;
        else                   gap_cnt_d = gap_cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // output logic: next values of the registered outputs
  always_comb begin
    slave_d       = slave_q;
    err_d         = err_q;
    master_data_d = master_data_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_slave_d   = rsp_slave_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    cs1_d         = 1'b1;
    cs2_d         = 1'b1;
    cs3_d         = 1'b1;

    if (pop) begin
      slave_d = head_slave;
      err_d   = (head_slave == 2'd0);
      // word is on master_data for the whole SETUP cycle
      if (head_slave != 2'd0) master_data_d = head_data;
    end

    // single decode of one latched slave id keeps the selects mutually exclusive
    if (state_d == S_XFER) begin
      case (slave_q)
        2'd1:    cs1_d = 1'b0;
        2'd2:    cs2_d = 1'b0;
        2'd3:    cs3_d = 1'b0;
        default: ;
      endcase
    end

    case (state_q)
      S_CAPTURE: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = master_r;
        rsp_slave_d = slave_q;
        rsp_err_d   = 1'b0;
      end
      S_RESP: begin
        // the error path enters RESP without a response; build it on the first cycle
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_slave_d = slave_q;
          rsp_err_d   = err_q;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign cs1         = cs1_q;
  assign cs2         = cs2_q;
  assign cs3         = cs3_q;
  assign master_data = master_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_slave   = rsp_slave_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// tb/tb_spi_txn_sequencer.sv - directed self-checking bench for spi_txn_sequencer
module tb_spi_txn_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_slave;
  logic [15:0] req_data;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_slave;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        cs1, cs2, cs3;
  logic [15:0] master_data, master_r;
  logic        busy;

  always #5 clk = ~clk;

  spi_txn_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_slave(req_slave), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_slave(rsp_slave), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .cs1(cs1), .cs2(cs2), .cs3(cs3),
    .master_data(master_data), .master_r(master_r), .busy(busy)
  );

  assign master_r = {master_data[3:0], master_data[7:4], master_data[11:8], master_data[15:12]};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int overlap_cnt = 0, cs_low_total = 0, rsp_valid_total = 0;
  int high_run = 0, min_gap = 1000;
  bit seen_xfer = 1'b0;
  logic [1:0]  log_slave [$];
  logic [15:0] log_data  [$];
  logic        log_err   [$];

  always @(negedge clk) begin
    #1;
    if (int'(!cs1) + int'(!cs2) + int'(!cs3) > 1) overlap_cnt++;
    if (!cs1 || !cs2 || !cs3) begin
      cs_low_total++;
      if (seen_xfer && high_run > 0 && high_run < min_gap) min_gap = high_run;
      high_run  = 0;
      seen_xfer = 1'b1;
    end else begin
      high_run++;
    end
    if (rsp_valid) rsp_valid_total++;
    if (rst && rsp_valid && rsp_ready) begin
      log_slave.push_back(rsp_slave);
      log_data.push_back(rsp_data);
      log_err.push_back(rsp_err);
    end
  end

  task automatic send_wait(input logic [1:0] s, input logic [15:0] d,
                           output int first_cs, output int first_rsp,
                           output int sel_low, output int other_low,
                           output logic [15:0] md_at1);
    logic [2:0] csv;
    req_valid = 1'b1; req_slave = s; req_data = d;
    @(negedge clk);
    req_valid = 1'b0;
    first_cs = -1; first_rsp = -1; sel_low = 0; other_low = 0; md_at1 = '0;
    for (int k = 1; k <= 40 && first_rsp < 0; k++) begin
      @(negedge clk);
      if (k == 1) md_at1 = master_data;
      csv = {cs3, cs2, cs1};
      for (int j = 1; j <= 3; j++) begin
        if (!csv[j-1]) begin
          if (j == int'(s)) begin
            sel_low++;
            if (first_cs < 0) first_cs = k;
          end else begin
            other_low++;
          end
        end
      end
      if (rsp_valid) first_rsp = k;
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400 && busy; k++) @(negedge clk);
  endtask

  logic [1:0]  s2 [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
  logic [15:0] d2 [4] = '{16'h1234, 16'h00F0, 16'hBEEF, 16'h8001};
  logic [15:0] e2 [4] = '{16'h4321, 16'h0F00, 16'hFEEB, 16'h1008};

  initial begin
    int fc, fr, sl, ol, rr_k, c0, rv0, nlog, unstable, first_low;
    logic [15:0] md1;
    logic rv1, busy_seen;

    rst = 1'b0; req_valid = 1'b0; req_slave = '0; req_data = '0; rsp_ready = 1'b0;

    @(negedge clk);
    chk("rst_cs1", cs1, 1'b1);
    chk("rst_cs2", cs2, 1'b1);
    chk("rst_cs3", cs3, 1'b1);
    chk("rst_master_data", master_data, 16'h0000);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 16'h0000);
    chk("rst_rsp_slave", rsp_slave, 2'd0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    rst = 1'b1;
    @(negedge clk);

    send_wait(2'd2, 16'hA5C3, fc, fr, sl, ol, md1);
    chk("t1_setup_data", md1, 16'hA5C3);
    chk("t1_cs_first_low", fc, 2);
    chk("t1_cs2_low_clocks", sl, 17);
    chk("t1_other_cs_low", ol, 0);
    chk("t1_rsp_latency", fr, 20);
    chk("t1_rsp_data", rsp_data, 16'h3C5A);
    chk("t1_rsp_slave", rsp_slave, 2'd2);
    chk("t1_rsp_err", rsp_err, 1'b0);

    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_slave = s2[i]; req_data = d2[i];
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("t2_full_ready", req_ready, 1'b0);
    chk("t2_busy", busy, 1'b1);
    chk("t2_hold_valid", rsp_valid, 1'b1);
    chk("t2_hold_data", rsp_data, 16'h3C5A);
    rsp_ready = 1'b1;
    rr_k = -1;
    for (int k = 1; k <= 20 && rr_k < 0; k++) begin
      @(negedge clk);
      if (req_ready) rr_k = k;
    end
    chk("t2_ready_after_pop", rr_k, 4);
    wait_idle();
    chk("t2_idle", busy, 1'b0);
    rsp_ready = 1'b0;
    chk("t2_log_size", log_data.size(), 5);
    chk("t2_rsp0_slave", log_slave[0], 2'd2);
    chk("t2_rsp0_data", log_data[0], 16'h3C5A);
    for (int i = 0; i < 4; i++) begin
      chk("t2_rsp_slave", log_slave[i+1], s2[i]);
      chk("t2_rsp_data", log_data[i+1], e2[i]);
    end
    chk("t2_min_gap", min_gap, 6);
    chk("t2_overlap", overlap_cnt, 0);

    c0 = cs_low_total;
    req_valid = 1'b1; req_slave = 2'd0; req_data = 16'hFFFF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("t3_no_rsp_yet", rsp_valid, 1'b0);
    @(negedge clk);
    chk("t3_rsp_valid", rsp_valid, 1'b1);
    chk("t3_rsp_err", rsp_err, 1'b1);
    chk("t3_rsp_data", rsp_data, 16'h0000);
    chk("t3_rsp_slave", rsp_slave, 2'd0);
    chk("t3_master_data_held", master_data, 16'h8001);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("t3_rsp_cleared", rsp_valid, 1'b0);
    chk("t3_no_cs", cs_low_total, c0);
    wait_idle();

    send_wait(2'd3, 16'h5A5A, fc, fr, sl, ol, md1);
    chk("t3n_cs_first_low", fc, 2);
    chk("t3n_cs3_low_clocks", sl, 17);
    chk("t3n_rsp_latency", fr, 20);
    chk("t3n_rsp_data", rsp_data, 16'hA5A5);
    chk("t3n_rsp_slave", rsp_slave, 2'd3);

    req_valid = 1'b1; req_slave = 2'd1; req_data = 16'h0F0F;
    @(negedge clk);
    req_valid = 1'b0;
    c0 = cs_low_total;
    unstable = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== 16'hA5A5 || rsp_slave !== 2'd3 || rsp_err !== 1'b0)
        unstable++;
    end
    chk("t4_bp_stable", unstable, 0);
    chk("t4_bp_no_cs", cs_low_total, c0);
    rsp_ready = 1'b1;
    first_low = -1; rv1 = 1'b1;
    for (int k = 1; k <= 20 && first_low < 0; k++) begin
      @(negedge clk);
      if (k == 1) rv1 = rsp_valid;
      if (!cs1) first_low = k;
    end
    chk("t4_bp_handshake", rv1, 1'b0);
    chk("t4_bp_restart", first_low, 5);
    wait_idle();
    chk("t4_log_size", log_data.size(), 8);
    chk("t4_err_log", log_err[5], 1'b1);
    chk("t4_err_data", log_data[5], 16'h0000);
    chk("t4_bp_data", log_data[6], 16'hA5A5);
    chk("t4_next_slave", log_slave[7], 2'd1);
    chk("t4_next_data", log_data[7], 16'hF0F0);

    req_valid = 1'b1; req_slave = 2'd1; req_data = 16'h1111;
    @(negedge clk);
    req_slave = 2'd2; req_data = 16'h2222;
    @(negedge clk);
    req_slave = 2'd3; req_data = 16'h3333;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("t5_mid_xfer", cs1, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_cs1", cs1, 1'b1);
    chk("t5_cs2", cs2, 1'b1);
    chk("t5_cs3", cs3, 1'b1);
    chk("t5_rsp_valid", rsp_valid, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_req_ready", req_ready, 1'b1);
    rst = 1'b1;
    c0 = cs_low_total; rv0 = rsp_valid_total; nlog = log_data.size(); busy_seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    chk("t5_no_busy", busy_seen, 1'b0);
    chk("t5_no_cs", cs_low_total, c0);
    chk("t5_no_stale_rsp", rsp_valid_total, rv0);
    chk("t5_no_log", log_data.size(), nlog);
    chk("final_overlap", overlap_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
